// File: rtl/vec_sum_acc_pkg.sv
// vec_sum_acc_pkg: shared definitions for vec_sum_acc.
// Holds the FSM state encoding and the beat-count width.
package vec_sum_acc_pkg;
  localparam int CNT_W = 16;
  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;
endpackage

// File: rtl/vec_sum_acc_wallace_adder.sv
// wallace_adder: combinational sum of N packed W-bit words, result modulo 2^W.
// Ports: in_data (N words, word k at [k*W +: W]), sum (W-bit total).
module wallace_adder
  import vec_sum_acc_pkg::*;
#(
  parameter int W = 40,
  parameter int N = 4
) (
  input  logic [W*N-1:0] in_data,
  output logic [W-1:0]   sum
);
  logic [W-1:0] s, c;
  // Carry-save reduction keeps one carry-propagate add at the very end.
  always_comb begin
    s = '0;
    c = '0;
    for (int k = 0; k < N; k++)
      {s, c} = {s ^ c ^ in_data[k*W +: W],
                ((s & c) | (s & in_data[k*W +: W]) | (c & in_data[k*W +: W])) << 1};
    sum = s + c;
  end
endmodule

// File: rtl/vec_sum_acc.sv
// vec_sum_acc: accumulates bursts of N-word beats and presents one total per burst.
// Ports: clk, rst_n (async active-low); in_data/in_valid/in_last/in_ready beat input;
//        out_sum/out_count/out_sat/out_valid/out_ready result output.
// Macro VEC_SUM_ACC_SAT_EN: clamp the accumulator on overflow and report a sticky
//        per-burst out_sat; when undefined the accumulator wraps and out_sat is 0.
module vec_sum_acc
  import vec_sum_acc_pkg::*;
#(
  parameter int W     = 32,
  parameter int N     = 4,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W*N-1:0]   in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [ACC_W*N-1:0] ext;
  logic [ACC_W-1:0]   beat_sum, s1_sum, acc, acc_nxt, base;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               s1_valid, s1_last, s1_adv, first;
  state_t             state, state_nxt;

  for (genvar k = 0; k < N; k++) begin : g_ext
    assign ext[k*ACC_W +: ACC_W] = ACC_W'(in_data[k*W +: W]);
  end

  wallace_adder #(.W(ACC_W), .N(N)) u_add (.in_data(ext), .sum(beat_sum));

  assign s1_adv    = s1_valid && state == ACC;
  assign in_ready  = !s1_valid || s1_adv;
  assign out_valid = state == HOLD;
  assign base      = first ? '0 : acc;
  assign cnt_nxt   = first ? CNT_W'(1) : (&cnt ? cnt : cnt + 1'b1);

`ifdef VEC_SUM_ACC_SAT_EN
  logic             sat, sat_nxt;
  logic [ACC_W:0]   raw;
  assign raw     = {1'b0, base} + {1'b0, s1_sum};
  assign acc_nxt = raw[ACC_W] ? '1 : raw[ACC_W-1:0];
  assign sat_nxt = (!first && sat) || raw[ACC_W];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sat     <= 1'b0;
      out_sat <= 1'b0;
    end else if (s1_adv) begin
      sat <= sat_nxt;
      if (s1_last) out_sat <= sat_nxt;
    end
`else
  assign acc_nxt = base + s1_sum;
  assign out_sat = 1'b0;
`endif

  always_comb
    state_nxt = state == ACC ? (s1_adv && s1_last ? HOLD : ACC) : (out_ready ? ACC : HOLD);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;

  // first is already 1 when HOLD is entered (set by the last beat), so the
  // return to ACC needs no extra bookkeeping.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      first     <= 1'b1;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_sum    <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_sum   <= '0;
      out_count <= '0;
    end else begin
      if (in_valid && in_ready) begin
        s1_valid <= 1'b1;
        s1_sum   <= beat_sum;
        s1_last  <= in_last;
      end else if (s1_adv) s1_valid <= 1'b0;
      if (s1_adv) begin
        acc   <= acc_nxt;
        cnt   <= cnt_nxt;
        first <= s1_last;
        if (s1_last) begin
          out_sum   <= acc_nxt;
          out_count <= cnt_nxt;
        end
      end
    end
endmodule

// File: tb/tb_vec_sum_acc.sv
// tb_vec_sum_acc: self-checking bench for vec_sum_acc (W=8, N=4).
// Two instances share stimulus: ACC_W=40 (no overflow) and ACC_W=10 (overflow cases).
// Honours VEC_SUM_ACC_SAT_EN for the expected clamp/wrap behaviour.
module tb_vec_sum_acc;
`ifdef VEC_SUM_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] in_data;
  logic        in_valid, in_last, in_ready, in_ready2;
  logic [39:0] out_sum;
  logic [9:0]  out_sum2;
  logic [15:0] out_count, out_count2;
  logic        out_sat, out_sat2, out_valid, out_valid2, out_ready, rnd_bit = 1'b1;
  int          rdy_mode = 1;

  typedef struct { longint total; longint cnt; } res_t;
  res_t   exp_q[$];
  longint cur_total = 0, cur_cnt = 0;
  int     n_cmp = 0, n_err = 0, n_push = 0, n_pop = 0;

  always #5 clk = ~clk;
  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
  assign out_ready = rdy_mode == 2 ? rnd_bit : rdy_mode[0];

  vec_sum_acc #(.W(8), .N(4), .ACC_W(40)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_sum(out_sum), .out_count(out_count), .out_sat(out_sat),
    .out_valid(out_valid), .out_ready(out_ready));

  vec_sum_acc #(.W(8), .N(4), .ACC_W(10)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready2), .out_sum(out_sum2), .out_count(out_count2), .out_sat(out_sat2),
    .out_valid(out_valid2), .out_ready(out_ready));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic longint bsum(input logic [31:0] d);
    return longint'(d[7:0]) + longint'(d[15:8]) + longint'(d[23:16]) + longint'(d[31:24]);
  endfunction

  // 10-bit accumulator: clamping per add equals clamping the exact total,
  // and wrapping per add equals the exact total modulo 1024.
  function automatic longint exp_sum10(input longint t);
    return (SAT && t > 1023) ? 1023 : t % 1024;
  endfunction

  function automatic longint exp_sat10(input longint t);
    return (SAT && t > 1023) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    res_t e;
    #2;
    if (rst_n && out_valid && out_ready) begin
      chk("result_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_pop++;
        chk("sum", out_sum, e.total);
        chk("count", out_count, e.cnt);
        chk("sat", out_sat, 0);
        chk("valid2", out_valid2, 1);
        chk("sum2", out_sum2, exp_sum10(e.total));
        chk("count2", out_count2, e.cnt);
        chk("sat2", out_sat2, exp_sat10(e.total));
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic last);
    int n = 0;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    @(negedge clk);
    in_valid  = 1'b0;
    cur_total += bsum(d);
    cur_cnt++;
    if (last) begin
      exp_q.push_back('{cur_total, cur_cnt});
      n_push++;
      cur_total = 0;
      cur_cnt   = 0;
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid2", out_valid2, 0);
    n_push -= exp_q.size();
    exp_q.delete();
    cur_total = 0;
    cur_cnt   = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", in_ready, 1);
    chk("out_valid_after_reset", out_valid, 0);
  endtask

  initial begin
    int n;
    in_data  = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    do_reset();
    send_beat(pack(1, 2, 3, 4), 1'b0);
    send_beat(pack(255, 255, 255, 255), 1'b1);
    chk("latency_t1", out_valid, 0);
    @(negedge clk);
    chk("latency_t2", out_valid, 1);
    chk("sum_1030", out_sum, 1030);
    send_beat(pack(0, 0, 0, 7), 1'b1);
    send_beat(pack(255, 255, 255, 255), 1'b0);
    send_beat(pack(255, 255, 255, 255), 1'b1);
    repeat (4) @(negedge clk);
    chk("sum2_2040", out_sum2, SAT ? 1023 : 1016);
    chk("sat2_2040", out_sat2, SAT ? 1 : 0);
    rdy_mode = 0;
    send_beat(pack(10, 20, 30, 40), 1'b0);
    send_beat(pack(1, 1, 1, 1), 1'b1);
    send_beat(pack(2, 2, 2, 2), 1'b0);
    in_data  = pack(3, 3, 3, 3);
    in_last  = 1'b1;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_sum", out_sum, 104);
      chk("stall_count", out_count, 2);
      chk("stall_in_ready", in_ready, 0);
    end
    rdy_mode = 1;
    send_beat(pack(3, 3, 3, 3), 1'b1);
    repeat (4) @(negedge clk);
    send_beat(pack(9, 9, 9, 9), 1'b0);
    do_reset();
    send_beat(pack(5, 0, 0, 0), 1'b1);
    rdy_mode = 2;
    for (int b = 0; b < 6; b++)
      for (int i = 0; i < 3; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_beat($urandom, i == 2);
      end
    rdy_mode = 1;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("all_results_drained", exp_q.size(), 0);
    chk("result_count", n_pop, n_push);
    repeat (3) @(negedge clk);
    chk("idle_out_valid", out_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vec_sum_acc.md
VEC_SUM_ACC -- requirements
Module: vec_sum_acc

Interface
REQ-001 Parameter W, default 32: width of each input word, unsigned, W >= 1.
REQ-002 Parameter N, default 4: words per input beat, N >= 2.
REQ-003 Parameter ACC_W, default 40: accumulator and result width, ACC_W >= W + clog2(N).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 in_data  input  W*N  beat of N packed words, word k at bits [k*W +: W].
REQ-007 in_valid  input  1  beat present.
REQ-008 in_last  input  1  beat is the final beat of a burst; qualified by in_valid.
REQ-009 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-010 out_sum  output  ACC_W  burst total.
REQ-011 out_count  output  16  number of beats in the burst.
REQ-012 out_sat  output  1  burst total clamped (see Configuration).
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  result consumed when out_valid && out_ready.

Function
REQ-015 Stage S1 shall register the beat sum, the sum of all N words zero-extended to ACC_W, plus s1_valid and s1_last; the sum shall not wrap at W.
REQ-016 in_ready shall equal !s1_valid || s1_adv, where s1_adv = s1_valid && (state == ACC).
REQ-017 FSM states: ACC (accumulating) and HOLD (result presented); no other states.
REQ-018 In ACC, on s1_adv: acc <= (first ? 0 : acc) + s1_sum; cnt <= (first ? 1 : cnt + 1); first <= s1_last.
REQ-019 In ACC, on s1_adv with s1_last, the FSM shall go to HOLD, latch out_sum/out_count/out_sat from the updated values, and drive out_valid = 1 from the next cycle.
REQ-020 Latency: a last beat accepted in cycle t shall give out_valid = 1 in cycle t+2.
REQ-021 In HOLD, S1 shall stall (s1_adv = 0); on out handshake the FSM shall go to ACC next cycle with first = 1; there is no same-cycle bypass.
REQ-022 out_* shall be stable while out_valid && !out_ready.
REQ-023 A single-beat burst (in_last on the first beat) shall give out_count = 1 and out_sum = that beat sum.
REQ-024 cnt shall saturate at 16'hFFFF and never wrap.
REQ-025 Sustained throughput shall be one beat per cycle in ACC; each burst shall cost exactly one extra idle input cycle.

Reset
REQ-026 While rst_n = 0: state = ACC, first = 1, s1_valid = 0, acc = 0, cnt = 0, out_valid = 0, out_sum = 0, out_count = 0, out_sat = 0.
REQ-027 Reset asserted mid-burst or in HOLD shall discard all partial and pending results; after release, no stale output shall appear.
REQ-028 in_ready shall be 1 in the first cycle after reset release.

Configuration
REQ-029 Macro VEC_SUM_ACC_SAT_EN, when defined: an add overflowing ACC_W shall clamp acc to all-ones, and out_sat shall be a sticky flag per burst.
REQ-030 When VEC_SUM_ACC_SAT_EN is undefined: acc shall wrap modulo 2^ACC_W, and out_sat shall be constant 0.

Structure
REQ-031 The shared package shall hold the FSM state encoding (ACC = 1'b0, HOLD = 1'b1) and the count width constant (16).
REQ-032 The beat summation shall be one instance of sub-module wallace_adder (W = ACC_W, N = N) fed with the zero-extended words; S1 registers its output.
REQ-033 Everything else shall be flat in vec_sum_acc.

Verification
REQ-034 W=8, N=4: beats {1,2,3,4} then {255,255,255,255} with last, out_ready = 1 -> out_sum = 1030, out_count = 2, out_valid 2 cycles after the last beat.
REQ-035 Single beat {0,0,0,7} with last -> out_sum = 7, out_count = 1.
REQ-036 Hold out_ready = 0 for 5 cycles after out_valid with in_valid held high -> in_ready = 0 once S1 fills; out_* stable; the next burst resumes correctly after the handshake.
REQ-037 ACC_W=10, W=8, N=4: 2 beats of all-255 -> 2040 overflows 1023; with macro, out_sum = 1023 and out_sat = 1; without, out_sum = 1016 and out_sat = 0.
REQ-038 Assert rst_n = 0 for 1 cycle mid-burst, then send {5,0,0,0} with last -> out_sum = 5, out_count = 1.
REQ-039 Back-to-back 3-beat bursts with random in_valid gaps -> each result matches a reference model; no beat lost or duplicated.
